// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: framer FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_mode_t;

  // The reserved encoding behaves like "no parity".
  function automatic logic parity_enabled(input parity_mode_t mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each serial bit with tick.
module uart_baud_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  // A single-cycle bit still needs a one-bit counter that simply stays at 0.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB-first, optional parity,
// one or two stop bits, each held for CLKS_PER_BIT clocks.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  state_t            state, next_state;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              par_bit, par_en, stop2_q;
  logic              tick, accept;
  logic              tx_next, done_next;

  assign ready  = (state == IDLE) && !reset;
  assign busy   = (state != IDLE);
  assign accept = valid && ready;

  uart_baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (busy),
    .tick  (tick)
  );

  // tx and done are registered alongside the state so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      tx    <= tx_next;
      done  <= done_next;
    end
  end

  always_comb begin
    next_state = state;
    tx_next    = tx;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          next_state = START;
          tx_next    = 1'b0;
        end
      end
      START: if (tick) begin
        next_state = DATA;
        tx_next    = shreg[0];
      end
      // shreg shifts on the same edge, so the next bit is currently at index 1.
      DATA: if (tick) begin
        if (bit_idx == LAST_BIT) begin
          if (par_en) begin
            next_state = PARITY;
            tx_next    = par_bit;
          end else begin
            next_state = STOP;
            tx_next    = 1'b1;
          end
        end else begin
          tx_next = shreg[1];
        end
      end
      PARITY: if (tick) begin
        next_state = STOP;
        tx_next    = 1'b1;
      end
      STOP: if (tick && (!stop2_q || bit_idx[0])) begin
        next_state = IDLE;
        done_next  = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame settings are frozen at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
      par_en  <= 1'b0;
      stop2_q <= 1'b0;
    end else if (accept) begin
      shreg   <= data;
      bit_idx <= '0;
      par_bit <= (^data) ^ (parity_mode_t'(parity_mode) == PAR_ODD);
      par_en  <= parity_enabled(parity_mode_t'(parity_mode));
      stop2_q <= stop2;
    end else if (tick) begin
      case (state)
        DATA: begin
          if (bit_idx == LAST_BIT) begin
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + IW'(1);
            shreg   <= shreg >> 1;
          end
        end
        STOP:    bit_idx <= bit_idx + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer; successor to the fixed 4-state serializer controller. It accepts one data word per valid/ready handshake and serialises it LSB-first on `tx` as start bit, DATA_W data bits, an optional parity bit and one or two stop bits. Every bit is held for CLKS_PER_BIT clocks. The block sits between the host-side data path and the serial output pin, and it owns all bit timing internally.

## Interface
- DATA_W, default 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must be ≥ 1.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  host offers `data`.
- data  input  DATA_W  word to transmit.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  input  1  0 selects one stop bit, 1 selects two.
- ready  output  1  framer can accept a word (IDLE and not in reset).
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on `valid && ready`. On that accept edge, capture `data`, `parity_mode` and `stop2` into internal registers. Input changes during a frame have no effect.
- START → DATA after 1 bit time.
- DATA → PARITY after DATA_W bit times when parity is enabled; otherwise DATA → STOP.
- PARITY → STOP after 1 bit time.
- STOP → IDLE after 1 or 2 bit times, per the captured `stop2`.
- Per-state `tx` value: START 0; DATA `shreg[0]`, with the shift register moving right at each bit boundary; PARITY the parity bit; STOP and IDLE 1.
- Even parity bit = XOR of the captured word. Odd parity bit = its inverse. Parity is computed at capture and registered.
- Baud counter runs 0..CLKS_PER_BIT−1 and wraps. A bit boundary occurs at count CLKS_PER_BIT−1. The counter is cleared on accept.
- Bit-index counter runs 0..DATA_W−1 in DATA and also counts the stop bits. It is sized with $clog2 and has no overflow beyond those ranges.
- `tx` is registered and changes on the same edge as the state register. No combinational path exists from inputs to `tx`.
- `ready` = (state == IDLE) && !reset. This is the only combinational output.

## Timing
- Reset values: state IDLE, `tx` = 1, `busy` = 0, `done` = 0, `ready` = 0 while `reset` is high. `ready` = 1 on the first cycle after reset deasserts.
- Accept at edge E: from E, `tx` = 0 and `busy` = 1.
- Data bit i occupies the cycles from edge E + (1+i)·C to E + (2+i)·C, where C = CLKS_PER_BIT.
- Frame length N·C cycles, with N = 1 + DATA_W + (parity ? 1 : 0) + (stop2 ? 2 : 1).
- At edge E + N·C: state becomes IDLE, `done` = 1 for exactly one cycle, `busy` = 0 and `ready` = 1.
- Back-to-back with `valid` held: the next accept is at edge E + N·C + 1. The minimum line-high gap between frames is 1 cycle beyond the stop bit(s).
- `valid` while busy: ignored; the word is not consumed because `ready` = 0.
- Reset mid-frame: at the next edge the frame is aborted, state becomes IDLE, `tx` = 1, and no `done` pulse is produced.
- C = 1: every state lasts one cycle. The counter is constant 0 and the boundary condition is always true.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] state_t {IDLE, START, DATA, PARITY, STOP}`
  - `typedef enum logic [1:0] parity_mode_t {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD}`
- Sub-module `uart_baud_timer`: parameter CLKS_PER_BIT; inputs `clk`, `reset`, `clear`, `en`; output `tick`, high on the last cycle of each bit. The framer instantiates one and advances its FSM on `tick`.
- The framer contains: state register, next-state logic, shift register, bit-index counter, parity register and `tx`/`done` registers.

## Test plan
- DATA_W=8, C=4, parity none, one stop, `data` = 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles each; `done` pulses at accept + 40; `busy` low on that same cycle.
- Same word, even parity → parity bit 0, frame 44 cycles. Odd parity → parity bit 1. `stop2` = 1 → frame 48 cycles with 8 high cycles of stop.
- `valid` held high with 0x00 then 0xFF → second accept exactly 1 cycle after the first `done`; `ready` low throughout each frame; the word offered during busy is not lost.
- `data` and `parity_mode` changed mid-frame → the transmitted bits match the values captured at accept.
- `reset` asserted at cycle 17 of a frame → next cycle `tx` = 1, `busy` = 0, `ready` = 0 while reset is held, no `done`; a fresh frame after release is correct.
- C=1, DATA_W=5, odd parity, `data` = 0x1F → `tx` 0,1,1,1,1,1,0,1 on consecutive cycles; `done` at accept + 8.
